frame_sq_accum: RTL and testbench
=================================

// Module: frame_sq_accum
// PURPOSE
//  Upstream feeder of inv_sqrt in the WordDetect feature path. Squares signed feature
//  samples and sums them over a fixed-length frame. Emits one 32-bit energy word per
//  frame on sq_o/dv_o, which drive inv_sqrt's sq_i/dv_i directly. No backpressure.
// PARAMETERS
//  FRAME_LEN  64  samples per frame, 2..65535
//  SQ_SHIFT   0   right shift applied to the frame sum before saturation to 32 bits
//  SQ_FLOOR   8   minimum sq_o value when FRAME_SQ_FLOOR_EN is defined
// PORTS
//  clk        in   1   clock, all logic on rising edge
//  rst        in   1   synchronous reset, active high
//  dv_i       in   1   sample valid, one sample per cycle max
//  smp_i      in   16  signed sample
//  clr_i      in   1   abort current partial frame
//  dv_o       out  1   one-cycle pulse, sq_o valid
//  sq_o       out  32  unsigned frame energy, held until next dv_o
//  frm_cnt_o  out  16  completed-frame counter, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: dv_o=0, sq_o=0, frm_cnt_o=0, sample counter=0, accumulator=0, pipe valids=0.
//  Two-stage pipeline:
//   S1: on dv_i, register sq1=smp_i*smp_i (31b unsigned, max 2^30). Register last1=(cnt==FRAME_LEN-1).
//       cnt increments on dv_i and wraps to 0 after FRAME_LEN-1.
//   S2: acc (48b) += sq1 when S1 valid.
//       If last1: sq_o<=SAT32((acc+sq1)>>SQ_SHIFT), dv_o<=1, frm_cnt_o++, acc<=0.
//  Latency: dv_i with the last sample of a frame at edge t -> dv_o high in the cycle after edge t+2.
//  States: IDLE (cnt==0), ACCUM (0<cnt). No other FSM states; no bubble between frames.
//  The next frame's first sample can arrive the cycle after the last; acc restarts from 0 that cycle.
//  SAT32: any bit above 31 set after the shift -> 0xFFFFFFFF.
//  Gaps in dv_i: allowed; S1/S2 hold, dv_o stays 0.
//  clr_i: cnt<=0, acc<=0, S1 valid<=0; a same-cycle dv_i sample is dropped (clr wins).
//   An already-issued last1 still completes its dv_o unaffected.
//  rst mid-frame: partial sum discarded, no dv_o; rst overrides clr_i and dv_i.
//  dv_o is never high two consecutive cycles, because FRAME_LEN>=2.
// CONFIGURATION
//  FRAME_SQ_FLOOR_EN defined: sq_o = max(SAT32(...), SQ_FLOOR). Protects inv_sqrt from 0 input.
//  Not defined: sq_o = SAT32(...) exactly, so 0 is possible.
// STRUCTURE
//  Shared package wd_pkg: SMP_W=16, SQ_W=32, ACC_W=48, SAT32 max constant.
//  One sub-module: frame_sq_sat_shift (combinational shift + saturate + optional floor),
//   instanced in S2.
// TESTING
//  FRAME_LEN=4, samples 1,-2,3,4 -> one dv_o 2 cycles after last dv_i, sq_o=30, frm_cnt_o=1.
//  FRAME_LEN=8, SHIFT=0, eight -32768 (sum 2^33) -> sq_o=0xFFFFFFFF; with SHIFT=2 -> 0x80000000.
//  FRAME_LEN=4, 12 contiguous samples all 3 -> three dv_o, 4 cycles apart, each sq_o=36, frm_cnt_o=3.
//  FRAME_LEN=4, 2 samples of 5, clr_i, then 1,1,1,1 -> single dv_o, sq_o=4.
//  FRAME_LEN=4, four zeros -> sq_o=8 with FRAME_SQ_FLOOR_EN, sq_o=0 without.
//  rst after 3 of 4 samples of 7, then 1,1,1,1 -> no dv_o before reset, then sq_o=4, frm_cnt_o=1.

Source files
------------

// File: rtl/wd_pkg.sv
// Shared definitions for the WordDetect feature path: datapath widths,
// the 32-bit saturation ceiling and the frame accumulator state encoding.
package wd_pkg;

    localparam int SMP_W = 16;   // signed feature sample
    localparam int SQ1_W = 31;   // one squared sample, max 2^30
    localparam int SQ_W  = 32;   // frame energy word handed to inv_sqrt
    localparam int ACC_W = 48;   // frame sum, holds 65535 * 2^30 without overflow
    localparam int CNT_W = 16;   // sample index and completed-frame counter

    localparam logic [SQ_W-1:0] SAT32_MAX = 32'hFFFF_FFFF;

    // IDLE: no sample of the current frame taken yet; ACCUM: frame in progress.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } frame_state_t;

endpackage

// File: rtl/frame_sq_sat_shift.sv
// Reduces a 48-bit frame sum to the 32-bit energy word: right shift by
// SQ_SHIFT, saturate to 0xFFFFFFFF, and - when FRAME_SQ_FLOOR_EN is
// defined - clamp from below to SQ_FLOOR so inv_sqrt never sees zero.
module frame_sq_sat_shift
    import wd_pkg::*;
#(
    parameter int SQ_SHIFT = 0,
    parameter int SQ_FLOOR = 8
) (
    input  logic [ACC_W-1:0] sum,
    output logic [SQ_W-1:0]  sq
);

`ifdef FRAME_SQ_FLOOR_EN
    localparam bit FLOOR_EN = 1'b1;
`else
    localparam bit FLOOR_EN = 1'b0;
`endif

    // With the floor disabled the clamp value is zero, which leaves the
    // saturated result untouched.
    localparam logic [SQ_W-1:0] FLOOR_VAL = FLOOR_EN ? SQ_W'(SQ_FLOOR) : '0;

    logic [ACC_W-1:0] shifted;
    logic [SQ_W-1:0]  sat;

    // Shift, then saturate on any surviving bit above 31, then apply the floor.
    always_comb begin
        shifted = sum >> SQ_SHIFT;
        if (|shifted[ACC_W-1:SQ_W]) begin
            sat = SAT32_MAX;
        end else begin
            sat = shifted[SQ_W-1:0];
        end
        sq = (sat > FLOOR_VAL) ? sat : FLOOR_VAL;
    end

endmodule

// File: rtl/frame_sq_accum.sv
// Frame energy accumulator feeding inv_sqrt. Squares signed samples and sums
// them over FRAME_LEN samples, emitting one saturated 32-bit energy word per
// frame as a one-cycle dv_o pulse. No backpressure on either side.
// Optional feature macro: FRAME_SQ_FLOOR_EN (floors sq_o at SQ_FLOOR).
//
// Handshake: dv_i marks smp_i valid for exactly the cycle it is high; there
// is no ready, every valid sample is consumed. dv_o is a single-cycle pulse
// and sq_o holds its value until the next pulse. The last sample of a frame
// is taken into stage 1 on edge t+1 and dv_o rises on edge t+2.
module frame_sq_accum
    import wd_pkg::*;
#(
    parameter int FRAME_LEN = 64,
    parameter int SQ_SHIFT  = 0,
    parameter int SQ_FLOOR  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dv_i,
    input  logic signed [SMP_W-1:0] smp_i,
    input  logic                    clr_i,
    output logic                    dv_o,
    output logic [SQ_W-1:0]         sq_o,
    output logic [CNT_W-1:0]        frm_cnt_o,
    output frame_state_t            dbg_state
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    // Stage 1 registers
    logic [CNT_W-1:0] cnt;
    logic             v1;
    logic             last1;
    logic [SQ1_W-1:0] sq1;
    frame_state_t     state;

    // Stage 2 registers
    logic [ACC_W-1:0] acc;

    // Squaring at 31 bits is exact: the largest square is (-32768)^2 = 2^30,
    // so the result modulo 2^31 is the true unsigned square.
    logic signed [SQ1_W-1:0] smp_x;
    logic signed [SQ1_W-1:0] prod;
    logic [ACC_W-1:0]        sum_next;
    logic [SQ_W-1:0]         sq_final;

    assign smp_x     = {{(SQ1_W-SMP_W){smp_i[SMP_W-1]}}, smp_i};
    assign prod      = smp_x * smp_x;
    assign sum_next  = acc + {{(ACC_W-SQ1_W){1'b0}}, sq1};
    assign dbg_state = state;

    frame_sq_sat_shift #(
        .SQ_SHIFT (SQ_SHIFT),
        .SQ_FLOOR (SQ_FLOOR)
    ) u_sat_shift (
        .sum (sum_next),
        .sq  (sq_final)
    );

    // Stage 1: square the sample, track the position within the frame and
    // flag the frame's last sample. clr_i drops any same-cycle sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            v1    <= 1'b0;
            last1 <= 1'b0;
            sq1   <= '0;
            state <= ST_IDLE;
        end else if (clr_i) begin
            cnt   <= '0;
            v1    <= 1'b0;
            state <= ST_IDLE;
        end else if (dv_i) begin
            sq1   <= prod;
            v1    <= 1'b1;
            last1 <= (cnt == LAST_IDX);
            if (cnt == LAST_IDX) begin
                cnt   <= '0;
                state <= ST_IDLE;
            end else begin
                cnt   <= cnt + 1'b1;
                state <= ST_ACCUM;
            end
        end else begin
            v1 <= 1'b0;
        end
    end

    // Stage 2: accumulate squares; on the last square publish the saturated
    // frame energy and restart the sum. A last square already in stage 1
    // completes even if clr_i arrives alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            dv_o      <= 1'b0;
            sq_o      <= '0;
            frm_cnt_o <= '0;
        end else begin
            dv_o <= 1'b0;
            if (v1 && last1) begin
                sq_o      <= sq_final;
                dv_o      <= 1'b1;
                frm_cnt_o <= frm_cnt_o + 1'b1;
                acc       <= '0;
            end else if (clr_i) begin
                acc <= '0;
            end else if (v1) begin
                acc <= sum_next;
            end
        end
    end

endmodule

// File: tb/tb_frame_sq_accum.sv
// Bench for frame_sq_accum. Two instances share one input stream:
// A with FRAME_LEN=4/SQ_SHIFT=0 and B with FRAME_LEN=8/SQ_SHIFT=2.
// A frame-level model predicts outputs; directed sequences pin literal values.
module tb_frame_sq_accum;
    import wd_pkg::*;

    localparam int N    = 2;
    localparam int FL_A = 4;
    localparam int SH_A = 0;
    localparam int FL_B = 8;
    localparam int SH_B = 2;
    localparam int FLOOR = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              dv_i = 1'b0;
    logic              clr_i = 1'b0;
    logic signed [15:0] smp_i = '0;

    logic         dv_a, dv_b;
    logic [31:0]  sq_a, sq_b;
    logic [15:0]  cnt_a, cnt_b;
    frame_state_t st_a, st_b;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    frame_sq_accum #(.FRAME_LEN(FL_A), .SQ_SHIFT(SH_A), .SQ_FLOOR(FLOOR)) dut_a (
        .clk(clk), .rst(rst), .dv_i(dv_i), .smp_i(smp_i), .clr_i(clr_i),
        .dv_o(dv_a), .sq_o(sq_a), .frm_cnt_o(cnt_a), .dbg_state(st_a)
    );

    frame_sq_accum #(.FRAME_LEN(FL_B), .SQ_SHIFT(SH_B), .SQ_FLOOR(FLOOR)) dut_b (
        .clk(clk), .rst(rst), .dv_i(dv_i), .smp_i(smp_i), .clr_i(clr_i),
        .dv_o(dv_b), .sq_o(sq_b), .frm_cnt_o(cnt_b), .dbg_state(st_b)
    );

    // ---------------- behavioural model ----------------
    int          fl [N] = '{FL_A, FL_B};
    int          sh [N] = '{SH_A, SH_B};
    longint      part_sum [N];
    int          part_n [N];
    bit          pend_v [N];
    logic [31:0] pend_val [N];
    logic        exp_dv [N];
    logic [31:0] exp_sq [N];
    logic [15:0] exp_cnt [N];
    bit          model_ok = 1'b0;

    function automatic logic [31:0] energy(input longint sum, input int shift);
        longint      v;
        logic [31:0] r;
        v = sum >> shift;
        if (v > 64'd4294967295) r = 32'hFFFF_FFFF;
        else                    r = v[31:0];
`ifdef FRAME_SQ_FLOOR_EN
        if (r < FLOOR) r = FLOOR;
`endif
        return r;
    endfunction

    // A finished frame's energy appears on the edge after the one that took
    // its last sample; reset wipes everything, clear drops the partial frame.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                part_sum[i] = 0;
                part_n[i]   = 0;
                pend_v[i]   = 1'b0;
                pend_val[i] = '0;
                exp_dv[i]   = 1'b0;
                exp_sq[i]   = '0;
                exp_cnt[i]  = '0;
            end else begin
                exp_dv[i] = 1'b0;
                if (pend_v[i]) begin
                    exp_dv[i]  = 1'b1;
                    exp_sq[i]  = pend_val[i];
                    exp_cnt[i] = exp_cnt[i] + 16'd1;
                    pend_v[i]  = 1'b0;
                end
                if (clr_i) begin
                    part_sum[i] = 0;
                    part_n[i]   = 0;
                end else if (dv_i) begin
                    longint s;
                    s = smp_i;
                    part_sum[i] += s * s;
                    part_n[i]++;
                    if (part_n[i] == fl[i]) begin
                        pend_v[i]   = 1'b1;
                        pend_val[i] = energy(part_sum[i], sh[i]);
                        part_sum[i] = 0;
                        part_n[i]   = 0;
                    end
                end
            end
        end
        model_ok = 1'b1;
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Compare every cycle, half a period after the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            check("a.dv_o",      32'(dv_a),  32'(exp_dv[0]));
            check("a.sq_o",      sq_a,       exp_sq[0]);
            check("a.frm_cnt_o", 32'(cnt_a), 32'(exp_cnt[0]));
            check("a.state",     32'(st_a),  (part_n[0] == 0) ? 32'(ST_IDLE) : 32'(ST_ACCUM));
            check("b.dv_o",      32'(dv_b),  32'(exp_dv[1]));
            check("b.sq_o",      sq_b,       exp_sq[1]);
            check("b.frm_cnt_o", 32'(cnt_b), 32'(exp_cnt[1]));
            check("b.state",     32'(st_b),  (part_n[1] == 0) ? 32'(ST_IDLE) : 32'(ST_ACCUM));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit d, input int s, input bit c, input bit r);
        dv_i  = d;
        smp_i = 16'(s);
        clr_i = c;
        rst   = r;
        @(negedge clk);
    endtask

    task automatic send(input int s);
        drive(1'b1, s, 1'b0, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b0, 0, 1'b0, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int zero_exp;
`ifdef FRAME_SQ_FLOOR_EN
        zero_exp = FLOOR;
`else
        zero_exp = 0;
`endif
        do_reset();
        do_reset();
        check("lit.reset_dv",  32'(dv_a),  32'd0);
        check("lit.reset_sq",  sq_a,       32'd0);
        check("lit.reset_cnt", 32'(cnt_a), 32'd0);

        // 1,-2,3,4 -> 30, pulse two cycles after the last sample
        send(1); send(-2); send(3); send(4);
        check("lit.t1_dv_early", 32'(dv_a), 32'd0);
        idle();
        check("lit.t1_dv",  32'(dv_a),  32'd1);
        check("lit.t1_sq",  sq_a,       32'd30);
        check("lit.t1_cnt", 32'(cnt_a), 32'd1);
        idle();
        check("lit.t1_dv_off", 32'(dv_a), 32'd0);

        // eight -32768: A saturates twice, B gives 2^33 >> 2
        do_reset();
        for (int i = 0; i < 8; i++) send(-32768);
        idle();
        check("lit.t2_sq_a",  sq_a,       32'hFFFF_FFFF);
        check("lit.t2_cnt_a", 32'(cnt_a), 32'd2);
        check("lit.t2_dv_b",  32'(dv_b),  32'd1);
        check("lit.t2_sq_b",  sq_b,       32'h8000_0000);

        // twelve contiguous 3s: three back-to-back frames of 36
        do_reset();
        for (int i = 0; i < 12; i++) send(3);
        idle();
        check("lit.t3_sq_a",  sq_a,       32'd36);
        check("lit.t3_cnt_a", 32'(cnt_a), 32'd3);
        check("lit.t3_sq_b",  sq_b,       32'd18);

        // 5,5, clear (with a dropped sample), then 1,1,1,1 -> 4
        do_reset();
        send(5); send(5);
        drive(1'b1, 9, 1'b1, 1'b0);
        send(1); send(1); send(1); send(1);
        idle();
        check("lit.t4_sq_a",  sq_a,       32'd4);
        check("lit.t4_cnt_a", 32'(cnt_a), 32'd1);

        // four zeros -> floor or zero
        do_reset();
        for (int i = 0; i < 4; i++) send(0);
        idle();
        check("lit.t5_sq_a", sq_a, 32'(zero_exp));

        // reset mid-frame discards the partial sum
        do_reset();
        send(7); send(7); send(7);
        drive(1'b1, 7, 1'b0, 1'b1);
        check("lit.t6_cnt_rst", 32'(cnt_a), 32'd0);
        send(1); send(1); send(1); send(1);
        idle();
        check("lit.t6_sq_a",  sq_a,       32'd4);
        check("lit.t6_cnt_a", 32'(cnt_a), 32'd1);

        // randomized traffic: gaps, clears, occasional resets, mixed magnitudes
        for (int n = 0; n < 4000; n++) begin
            bit d, c, r;
            int s;
            r = ($urandom_range(0, 999) < 4);
            c = ($urandom_range(0, 99) < 2);
            d = ($urandom_range(0, 99) < 75);
            case ($urandom_range(0, 5))
                0:       s = -32768;
                1:       s = 32767;
                2:       s = int'($urandom_range(0, 65535)) - 32768;
                default: s = int'($urandom_range(0, 600)) - 300;
            endcase
            drive(d, s, c, r);
        end
        for (int n = 0; n < 4; n++) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
